// File: rtl/blast_pkg.sv
// Shared nucleotide codes, default widths and feeder FSM encoding.
// Holds the ASCII-to-code helper used by both sequence buffers.
package blast_pkg;

   localparam int unsigned DefLengthChar    = 3;
   localparam int unsigned DefLengthCounter = 8;
   localparam int unsigned DefLengthArray   = 4;

   localparam logic [DefLengthChar-1:0] NtA = 3'b001;
   localparam logic [DefLengthChar-1:0] NtG = 3'b010;
   localparam logic [DefLengthChar-1:0] NtT = 3'b011;
   localparam logic [DefLengthChar-1:0] NtC = 3'b100;
   localparam logic [DefLengthChar-1:0] NtN = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StStreamQ,
      StStreamS,
      StFinish
   } state_e;

   typedef struct packed {
      logic                     illegal;
      logic [DefLengthChar-1:0] code;
   } enc_t;

   // OR-ing 0x20 folds upper case onto lower case; no other byte lands on a letter used here.
   function automatic enc_t encode_nt(input logic [7:0] b);
      enc_t r;
      r.illegal = 1'b0;
      case (b | 8'h20)
         8'h61:   r.code = NtA;
         8'h67:   r.code = NtG;
         8'h74:   r.code = NtT;
         8'h63:   r.code = NtC;
         8'h6e:   r.code = NtN;
         default: begin
            r.code    = NtN;
            r.illegal = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/blast_seq_feeder_if.sv
// Host write port, stream outputs and context lookup lanes of the feeder.
interface blast_seq_feeder_if #(
   parameter int unsigned LENGTH_CHAR    = blast_pkg::DefLengthChar,
   parameter int unsigned LENGTH_COUNTER = blast_pkg::DefLengthCounter,
   parameter int unsigned LENGTH_ARRAY   = blast_pkg::DefLengthArray
);
   logic                                   wr_valid;
   logic                                   wr_sel;
   logic [7:0]                             wr_data;
   logic                                   wr_ready;
   logic                                   clr_q;
   logic                                   clr_s;
   logic                                   start;
   logic [1:0]                             start_mode;
   logic                                   query_enable;
   logic [LENGTH_CHAR-1:0]                 query_datastream;
   logic                                   sub_enable;
   logic [LENGTH_CHAR-1:0]                 sub_datastream;
   logic [LENGTH_COUNTER*LENGTH_ARRAY-1:0] Q_address_F, Q_address_R, S_address_F, S_address_R;
   logic [LENGTH_CHAR*LENGTH_ARRAY-1:0]    Q_context_F, Q_context_R, S_context_F, S_context_R;
   logic [LENGTH_COUNTER-1:0]              q_len;
   logic [LENGTH_COUNTER-1:0]              s_len;
   logic                                   busy;
   logic                                   done;
   logic                                   enc_err;
   logic                                   ovf;

   modport slave (
      input  wr_valid, wr_sel, wr_data, clr_q, clr_s, start, start_mode,
      input  Q_address_F, Q_address_R, S_address_F, S_address_R,
      output wr_ready, query_enable, query_datastream, sub_enable, sub_datastream,
      output Q_context_F, Q_context_R, S_context_F, S_context_R,
      output q_len, s_len, busy, done, enc_err, ovf
   );

   modport master (
      output wr_valid, wr_sel, wr_data, clr_q, clr_s, start, start_mode,
      output Q_address_F, Q_address_R, S_address_F, S_address_R,
      input  wr_ready, query_enable, query_datastream, sub_enable, sub_datastream,
      input  Q_context_F, Q_context_R, S_context_F, S_context_R,
      input  q_len, s_len, busy, done, enc_err, ovf
   );
endinterface

// File: rtl/blast_seq_buf.sv
// One encoded sequence buffer: append-only write port, length counter,
// a stream read port and registered forward/reverse context lookups.
module blast_seq_buf
   import blast_pkg::*;
#(
   parameter int unsigned LENGTH_CHAR    = DefLengthChar,
   parameter int unsigned LENGTH_COUNTER = DefLengthCounter,
   parameter int unsigned LENGTH_ARRAY   = DefLengthArray,
   parameter int unsigned LENGTH_ADN     = 128,
   localparam int unsigned IdxW          = $clog2(LENGTH_ADN)
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic                                   i_we,
   input  logic                                   i_clr,
   input  logic [7:0]                             i_data,
   output logic                                   o_illegal,
   input  logic [IdxW-1:0]                        i_rd_idx,
   output logic [LENGTH_CHAR-1:0]                 o_rd_data,
   input  logic [LENGTH_COUNTER*LENGTH_ARRAY-1:0] i_addr_f,
   input  logic [LENGTH_COUNTER*LENGTH_ARRAY-1:0] i_addr_r,
   output logic [LENGTH_CHAR*LENGTH_ARRAY-1:0]    o_ctx_f,
   output logic [LENGTH_CHAR*LENGTH_ARRAY-1:0]    o_ctx_r,
   output logic [LENGTH_COUNTER-1:0]              o_len,
   output logic                                   o_full
);

   logic [LENGTH_CHAR-1:0]              r_mem [LENGTH_ADN];
   logic [LENGTH_COUNTER-1:0]           r_len;
   logic [LENGTH_CHAR*LENGTH_ARRAY-1:0] r_ctx_f, r_ctx_r;
   logic [LENGTH_CHAR*LENGTH_ARRAY-1:0] w_ctx_f, w_ctx_r;
   enc_t                                w_enc;
   logic                                w_wr;

   assign w_enc     = encode_nt(i_data);
   assign o_illegal = w_enc.illegal;
   assign o_full    = (r_len == LENGTH_COUNTER'(LENGTH_ADN));
   // A clear wins over a same-cycle write; the full guard also keeps the index in range.
   assign w_wr      = i_we & ~i_clr & ~o_full;
   assign o_rd_data = r_mem[i_rd_idx];
   assign o_len     = r_len;
   assign o_ctx_f   = r_ctx_f;
   assign o_ctx_r   = r_ctx_r;

   always_ff @(posedge i_clk) begin
      if (w_wr) begin
         r_mem[r_len[IdxW-1:0]] <= LENGTH_CHAR'(w_enc.code);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_len <= '0;
      end else if (i_clr) begin
         r_len <= '0;
      end else if (w_wr) begin
         r_len <= r_len + LENGTH_COUNTER'(1);
      end
   end

   always_comb begin
      w_ctx_f = '0;
      w_ctx_r = '0;
      for (int j = 0; j < int'(LENGTH_ARRAY); j++) begin
         if (i_addr_f[j*LENGTH_COUNTER +: LENGTH_COUNTER] < r_len) begin
            w_ctx_f[j*LENGTH_CHAR +: LENGTH_CHAR] = r_mem[i_addr_f[j*LENGTH_COUNTER +: IdxW]];
         end
         if (i_addr_r[j*LENGTH_COUNTER +: LENGTH_COUNTER] < r_len) begin
            w_ctx_r[j*LENGTH_CHAR +: LENGTH_CHAR] = r_mem[i_addr_r[j*LENGTH_COUNTER +: IdxW]];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ctx_f <= '0;
         r_ctx_r <= '0;
      end else begin
         r_ctx_f <= w_ctx_f;
         r_ctx_r <= w_ctx_r;
      end
   end

endmodule

// File: rtl/blast_seq_feeder.sv
// Host-side feeder for Blastn_Array: buffers query/subject sequences,
// streams them on request and serves the array's context lookups.
module blast_seq_feeder
   import blast_pkg::*;
#(
   parameter int unsigned LENGTH_CHAR    = DefLengthChar,
   parameter int unsigned LENGTH_COUNTER = DefLengthCounter,
   parameter int unsigned LENGTH_ARRAY   = DefLengthArray,
   parameter int unsigned LENGTH_ADN     = 128
) (
   input logic               array_clk,
   input logic               reset,
   blast_seq_feeder_if.slave bus
);

   localparam int unsigned IdxW = $clog2(LENGTH_ADN);

   state_e                    r_state, w_state_d;
   logic [LENGTH_COUNTER-1:0] r_idx, w_idx_d;
   logic [1:0]                r_mode, w_mode_d;
   logic                      r_enc_err, r_ovf;
   logic [LENGTH_COUNTER-1:0] w_q_len, w_s_len;
   logic                      w_q_full, w_s_full, w_q_ill, w_s_ill;
   logic [LENGTH_CHAR-1:0]    w_q_rd, w_s_rd;
   logic                      w_idle, w_sel_full, w_ready, w_q_we, w_s_we, w_q_en, w_s_en;

   assign w_idle     = (r_state == StIdle);
   assign w_sel_full = bus.wr_sel ? w_s_full : w_q_full;
   assign w_ready    = w_idle & ~w_sel_full & ~reset;
   assign w_q_we     = bus.wr_valid & w_ready & ~bus.wr_sel & ~bus.clr_q;
   assign w_s_we     = bus.wr_valid & w_ready & bus.wr_sel & ~bus.clr_s;

   blast_seq_buf #(
      .LENGTH_CHAR(LENGTH_CHAR), .LENGTH_COUNTER(LENGTH_COUNTER),
      .LENGTH_ARRAY(LENGTH_ARRAY), .LENGTH_ADN(LENGTH_ADN)
   ) u_qbuf (
      .i_clk(array_clk), .i_reset(reset), .i_we(w_q_we), .i_clr(bus.clr_q),
      .i_data(bus.wr_data), .o_illegal(w_q_ill), .i_rd_idx(r_idx[IdxW-1:0]),
      .o_rd_data(w_q_rd), .i_addr_f(bus.Q_address_F), .i_addr_r(bus.Q_address_R),
      .o_ctx_f(bus.Q_context_F), .o_ctx_r(bus.Q_context_R), .o_len(w_q_len), .o_full(w_q_full)
   );

   blast_seq_buf #(
      .LENGTH_CHAR(LENGTH_CHAR), .LENGTH_COUNTER(LENGTH_COUNTER),
      .LENGTH_ARRAY(LENGTH_ARRAY), .LENGTH_ADN(LENGTH_ADN)
   ) u_sbuf (
      .i_clk(array_clk), .i_reset(reset), .i_we(w_s_we), .i_clr(bus.clr_s),
      .i_data(bus.wr_data), .o_illegal(w_s_ill), .i_rd_idx(r_idx[IdxW-1:0]),
      .o_rd_data(w_s_rd), .i_addr_f(bus.S_address_F), .i_addr_r(bus.S_address_R),
      .o_ctx_f(bus.S_context_F), .o_ctx_r(bus.S_context_R), .o_len(w_s_len), .o_full(w_s_full)
   );

   always_ff @(posedge array_clk) begin
      if (reset) begin
         r_state   <= StIdle;
         r_idx     <= '0;
         r_mode    <= '0;
         r_enc_err <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
         r_mode  <= w_mode_d;
         if ((w_q_we & w_q_ill) | (w_s_we & w_s_ill)) begin
            r_enc_err <= 1'b1;
         end
         if (bus.wr_valid & w_sel_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      w_mode_d  = r_mode;
      case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_mode_d = bus.start_mode;
               w_idx_d  = '0;
               if (bus.start_mode[0] && (w_q_len != '0)) begin
                  w_state_d = StStreamQ;
               end else if (bus.start_mode[1] && (w_s_len != '0)) begin
                  w_state_d = StStreamS;
               end else begin
                  w_state_d = StFinish;
               end
            end
         end
         StStreamQ: begin
            // Compare with >= so a clear during streaming still terminates the phase.
            if (r_idx + LENGTH_COUNTER'(1) >= w_q_len) begin
               w_idx_d   = '0;
               w_state_d = (r_mode[1] && (w_s_len != '0)) ? StStreamS : StFinish;
            end else begin
               w_idx_d = r_idx + LENGTH_COUNTER'(1);
            end
         end
         StStreamS: begin
            if (r_idx + LENGTH_COUNTER'(1) >= w_s_len) begin
               w_idx_d   = '0;
               w_state_d = StFinish;
            end else begin
               w_idx_d = r_idx + LENGTH_COUNTER'(1);
            end
         end
         StFinish: w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   // Gating with reset drops the enables in the very cycle reset is sampled.
   assign w_q_en               = (r_state == StStreamQ) & ~reset;
   assign w_s_en               = (r_state == StStreamS) & ~reset;
   assign bus.wr_ready         = w_ready;
   assign bus.query_enable     = w_q_en;
   assign bus.query_datastream = w_q_en ? w_q_rd : '0;
   assign bus.sub_enable       = w_s_en;
   assign bus.sub_datastream   = w_s_en ? w_s_rd : '0;
   assign bus.busy             = ~w_idle & ~reset;
   assign bus.done             = (r_state == StFinish) & ~reset;
   assign bus.q_len            = w_q_len;
   assign bus.s_len            = w_s_len;
   assign bus.enc_err          = r_enc_err;
   assign bus.ovf              = r_ovf;

endmodule

// File: tb/tb_blast_seq_feeder.sv
// Randomised self-checking bench for blast_seq_feeder against a queue-based
// model of the two sequence buffers, the stream schedule and the sticky flags.
module tb_blast_seq_feeder;
   import blast_pkg::*;

   localparam int unsigned LC  = 3;
   localparam int unsigned LN  = 8;
   localparam int unsigned LA  = 4;
   localparam int unsigned ADN = 128;

   logic array_clk = 1'b0;
   logic reset     = 1'b1;

   blast_seq_feeder_if #(.LENGTH_CHAR(LC), .LENGTH_COUNTER(LN), .LENGTH_ARRAY(LA)) bus ();

   blast_seq_feeder #(
      .LENGTH_CHAR(LC), .LENGTH_COUNTER(LN), .LENGTH_ARRAY(LA), .LENGTH_ADN(ADN)
   ) dut (
      .array_clk(array_clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 array_clk = ~array_clk;

   int n_vec = 0;
   int n_err = 0;
   int qm[$];
   int sm[$];
   bit m_enc = 1'b0;
   bit m_ovf = 1'b0;

   function automatic int enc_code(input byte b);
      string s = "AGTCN";
      for (int i = 0; i < 5; i++) if (b == s[i] || b == s[i] + 8'd32) return i + 1;
      return 5;
   endfunction

   function automatic bit is_legal(input byte b);
      string s = "AGTCNagtcn";
      for (int i = 0; i < 10; i++) if (b == s[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int mctx(input bit s, input int a);
      if (s) return (a < sm.size()) ? sm[a] : 0;
      return (a < qm.size()) ? qm[a] : 0;
   endfunction

   function automatic byte rnd_legal();
      string s = "ACGTNacgtn";
      return s[$urandom_range(0, 9)];
   endfunction

   function automatic logic [31:0] raddr(input int len);
      logic [31:0] a;
      for (int j = 0; j < 4; j++) begin
         if ($urandom_range(0, 3) == 0) a[j*8 +: 8] = 8'd255;
         else a[j*8 +: 8] = 8'($urandom_range(0, (len + 2 > 254) ? 254 : len + 2));
      end
      return a;
   endfunction

   task automatic tick();
      @(posedge array_clk);
      #1;
   endtask

   // One host cycle: optional write/clear plus lookups on all four address buses.
   task automatic cyc(input bit v, input bit sel, input byte d, input bit cq, input bit cs,
                      input logic [31:0] qf, input logic [31:0] qr,
                      input logic [31:0] sf, input logic [31:0] sr);
      logic [11:0] e_qf, e_qr, e_sf, e_sr;
      bit full;
      bus.wr_valid = v; bus.wr_sel = sel; bus.wr_data = d; bus.clr_q = cq; bus.clr_s = cs;
      bus.Q_address_F = qf; bus.Q_address_R = qr; bus.S_address_F = sf; bus.S_address_R = sr;
      #1;
      full = sel ? (sm.size() == ADN) : (qm.size() == ADN);
      n_vec++;
      if (bus.wr_ready !== !full) begin
         n_err++;
         $display("FAIL wr_ready: got %b want %b (sel=%0d)", bus.wr_ready, !full, sel);
      end
      for (int j = 0; j < 4; j++) begin
         e_qf[j*3 +: 3] = 3'(mctx(1'b0, int'(qf[j*8 +: 8])));
         e_qr[j*3 +: 3] = 3'(mctx(1'b0, int'(qr[j*8 +: 8])));
         e_sf[j*3 +: 3] = 3'(mctx(1'b1, int'(sf[j*8 +: 8])));
         e_sr[j*3 +: 3] = 3'(mctx(1'b1, int'(sr[j*8 +: 8])));
      end
      if (v && full) m_ovf = 1'b1;
      else if (v && !(sel ? cs : cq)) begin
         if (!is_legal(d)) m_enc = 1'b1;
         if (sel) sm.push_back(enc_code(d));
         else qm.push_back(enc_code(d));
      end
      if (cq) qm.delete();
      if (cs) sm.delete();
      tick();
      bus.wr_valid = 1'b0; bus.clr_q = 1'b0; bus.clr_s = 1'b0;
      n_vec++;
      if ({bus.Q_context_F, bus.Q_context_R, bus.S_context_F, bus.S_context_R}
          !== {e_qf, e_qr, e_sf, e_sr}) begin
         n_err++;
         $display("FAIL contexts: got %h %h %h %h want %h %h %h %h", bus.Q_context_F,
                  bus.Q_context_R, bus.S_context_F, bus.S_context_R, e_qf, e_qr, e_sf, e_sr);
      end
      n_vec++;
      if ({bus.q_len, bus.s_len, bus.enc_err, bus.ovf} !==
          {8'(qm.size()), 8'(sm.size()), m_enc, m_ovf}) begin
         n_err++;
         $display("FAIL len_flags: got q=%0d s=%0d enc=%b ovf=%b want q=%0d s=%0d enc=%b ovf=%b",
                  bus.q_len, bus.s_len, bus.enc_err, bus.ovf, qm.size(), sm.size(), m_enc, m_ovf);
      end
   endtask

   task automatic wr(input bit sel, input byte d);
      cyc(1'b1, sel, d, 1'b0, 1'b0, raddr(qm.size()), raddr(qm.size()),
          raddr(sm.size()), raddr(sm.size()));
   endtask

   task automatic clr_both();
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, '1, '1, '1, '1);
   endtask

   // Start a run and check every cycle against the schedule: query codes, subject codes, done.
   task automatic run_stream(input logic [1:0] mode, input bit poke);
      int nq, ns;
      logic [9:0] got, want;
      nq = mode[0] ? qm.size() : 0;
      ns = mode[1] ? sm.size() : 0;
      bus.start = 1'b1; bus.start_mode = mode;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k <= nq + ns + 1; k++) begin
         if (k < nq) want = {1'b1, 3'(qm[k]), 1'b0, 3'b0, 1'b0, 1'b1};
         else if (k < nq + ns) want = {1'b0, 3'b0, 1'b1, 3'(sm[k-nq]), 1'b0, 1'b1};
         else if (k == nq + ns) want = {8'b0, 1'b1, 1'b1};
         else want = 10'b0;
         got = {bus.query_enable, bus.query_datastream, bus.sub_enable, bus.sub_datastream,
                bus.done, bus.busy};
         n_vec++;
         if (got !== want) begin
            n_err++;
            $display("FAIL stream mode=%b cycle %0d: got qe/qd/se/sd/done/busy=%b want %b",
                     mode, k, got, want);
         end
         if (k <= nq + ns) begin
            bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_vec++;
      if ({bus.busy, bus.done, bus.query_enable, bus.sub_enable, bus.query_datastream,
           bus.sub_datastream, bus.wr_ready} !== 11'b0) begin
         n_err++;
         $display("FAIL reset_outputs: busy=%b done=%b qe=%b se=%b rdy=%b want all 0",
                  bus.busy, bus.done, bus.query_enable, bus.sub_enable, bus.wr_ready);
      end
      reset = 1'b0;
      qm.delete(); sm.delete(); m_enc = 1'b0; m_ovf = 1'b0;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h03020100, 32'h0, 32'h03020100, 32'h0);
   endtask

   task automatic test_encode_lookup();
      string s = "AcGtN";
      for (int i = 0; i < 5; i++) wr(1'b0, s[i]);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h03020100, 32'h04030201, '1, '1);
      n_vec++;
      if ({bus.Q_context_F, bus.q_len} !== {12'b011_010_100_001, 8'd5}) begin
         n_err++;
         $display("FAIL acgtn_lookup: got %b len %0d want 011010100001 len 5",
                  bus.Q_context_F, bus.q_len);
      end
      for (int i = 0; i < 24; i++) wr(1'($urandom_range(0, 1)), rnd_legal());
   endtask

   task automatic test_stream();
      clr_both();
      wr(1'b0, "A"); wr(1'b0, "G"); wr(1'b0, "T");
      wr(1'b1, "C"); wr(1'b1, "C");
      run_stream(2'b11, 1'b0);
      run_stream(2'b10, 1'b1);
      clr_both();
      run_stream(2'b11, 1'b0);
      for (int it = 0; it < 8; it++) begin
         int lq, ls;
         clr_both();
         lq = $urandom_range(0, 6);
         ls = $urandom_range(0, 6);
         for (int i = 0; i < lq; i++) wr(1'b0, rnd_legal());
         for (int i = 0; i < ls; i++) wr(1'b1, rnd_legal());
         run_stream(2'($urandom_range(0, 3)), 1'b1);
      end
   endtask

   task automatic test_lookup_edges();
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '1, '1, '1, '1);
      wr(1'b0, rnd_legal()); wr(1'b0, rnd_legal());
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h01C800FF, 32'hFF0100C8, '1, '1);
      wr(1'b0, rnd_legal()); wr(1'b0, rnd_legal()); wr(1'b0, rnd_legal());
      cyc(1'b1, 1'b0, "G", 1'b0, 1'b0, 32'h05050505, 32'h05050505, '1, '1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h05050505, 32'h00000005, '1, '1);
   endtask

   task automatic test_overflow_enc();
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, '1, '1, '1, '1);
      for (int i = 0; i < int'(ADN); i++) wr(1'b1, rnd_legal());
      cyc(1'b1, 1'b1, "A", 1'b0, 1'b0, '1, '1, 32'h807F0100, 32'hFF7E8102);
      wr(1'b1, "T");
      cyc(1'b1, 1'b0, "A", 1'b1, 1'b0, '1, '1, '1, '1);
      wr(1'b0, "x");
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'hFF0100FF, 32'h0, '1, '1);
   endtask

   task automatic test_reset_mid();
      logic [9:0] got;
      clr_both();
      for (int i = 0; i < 10; i++) wr(1'b0, rnd_legal());
      bus.start = 1'b1; bus.start_mode = 2'b01;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
      #1;
      got = {bus.query_enable, bus.query_datastream, bus.sub_enable, bus.sub_datastream,
             bus.done, bus.busy};
      n_vec++;
      if (got !== 10'b0) begin
         n_err++;
         $display("FAIL reset_same_cycle: got %b want 0", got);
      end
      tick();
      got = {bus.query_enable, bus.query_datastream, bus.sub_enable, bus.sub_datastream,
             bus.done, bus.busy};
      n_vec++;
      if ({got, bus.q_len, bus.s_len} !== 26'b0) begin
         n_err++;
         $display("FAIL reset_mid_stream: got outs=%b q_len=%0d s_len=%0d want 0",
                  got, bus.q_len, bus.s_len);
      end
      reset = 1'b0;
      qm.delete(); sm.delete(); m_enc = 1'b0; m_ovf = 1'b0;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h03020100, 32'h0, 32'h0);
   endtask

   initial begin
      bus.wr_valid = 1'b0; bus.wr_sel = 1'b0; bus.wr_data = 8'h00;
      bus.clr_q = 1'b0; bus.clr_s = 1'b0; bus.start = 1'b0; bus.start_mode = 2'b00;
      bus.Q_address_F = '0; bus.Q_address_R = '0; bus.S_address_F = '0; bus.S_address_R = '0;
      test_reset();
      test_encode_lookup();
      test_stream();
      test_lookup_edges();
      test_overflow_enc();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/blast_seq_feeder.md
Name: blast_seq_feeder

Overview:
- Host-side feeder for Blastn_Array.
- Accepts ASCII nucleotide bytes for the query and subject sequences and encodes them into 3-bit codes held in two on-chip buffers.
- Streams each buffer into the array's query/subject datastream inputs with the matching enable.
- Answers the array's 4-lane forward/reverse context lookups (address in, context code out) from the same buffers.

Parameters:
- LENGTH_CHAR, 3, nucleotide code width
- LENGTH_COUNTER, 8, address/length width
- LENGTH_ARRAY, 4, context lookup lanes per direction
- LENGTH_ADN, 128, buffer depth per sequence (must be < 255)

Ports:
- array_clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  host byte valid
- wr_sel  in  1  0 = query buffer, 1 = subject buffer
- wr_data  in  8  ASCII nucleotide
- wr_ready  out  1  byte accepted when wr_valid & wr_ready
- clr_q  in  1  pulse: query length := 0
- clr_s  in  1  pulse: subject length := 0
- start  in  1  pulse: begin streaming
- start_mode  in  2  bit0 stream query, bit1 stream subject
- query_enable  out  1  query stream valid
- query_datastream  out  LENGTH_CHAR  query code
- sub_enable  out  1  subject stream valid
- sub_datastream  out  LENGTH_CHAR  subject code
- Q_address_F, Q_address_R, S_address_F, S_address_R  in  LENGTH_COUNTER*LENGTH_ARRAY each  lookup addresses
- Q_context_F, Q_context_R, S_context_F, S_context_R  out  LENGTH_CHAR*LENGTH_ARRAY each  lookup codes
- q_len, s_len  out  LENGTH_COUNTER  stored lengths
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse at end of stream
- enc_err  out  1  sticky: illegal byte seen
- ovf  out  1  sticky: write attempted to a full buffer

Behaviour:
- Reset: all outputs 0, both lengths 0, sticky flags 0, FSM in IDLE. Reset mid-stream aborts immediately; enables drop the same cycle the reset is sampled.
- Encoding, case-insensitive:
  - A=3'b001, G=3'b010, T=3'b011, C=3'b100, N=3'b101.
  - Any other byte is stored as N and sets enc_err.
- Writes:
  - wr_ready = (state==IDLE) & ~full(wr_sel).
  - An accepted byte is stored at index len and len increments.
  - wr_valid while full sets ovf; the byte is dropped and len is unchanged.
  - clr_x has priority over a simultaneous write to the same buffer; the write is dropped.
- FSM states: IDLE, STREAM_Q, STREAM_S, FINISH.
  - IDLE + start: go to STREAM_Q if mode[0] & q_len!=0; else STREAM_S if mode[1] & s_len!=0; else FINISH.
  - start while not IDLE is ignored.
  - STREAM_Q: query_enable=1, query_datastream=qbuf[idx]; idx runs 0..q_len-1, one code per clock, starting the cycle after start.
  - After the last query code, go directly (no gap) to STREAM_S if selected and non-empty, else FINISH.
  - STREAM_S: same as STREAM_Q, using sub_enable, sub_datastream and sbuf.
  - FINISH: done=1 for one cycle, datastreams 0, return to IDLE.
  - busy=1 in all states except IDLE.
  - Outside its stream phase, each datastream output is 0.
- Context lookup:
  - Registered, 1-cycle latency, lane j independent.
  - ctx[j] = buf[addr[j]] if addr[j] < len, else 0.
  - Address 255 therefore always returns 0, per lane only; other lanes are unaffected.
  - Lookups are valid in every state, including during streaming and writes.
  - A write and a lookup of the same index in the same cycle return the old contents (0 if beyond the old len).
- Buffers are flop arrays, LENGTH_ADN x LENGTH_CHAR each.
- Lengths saturate at LENGTH_ADN, so no wrap-around.

Decomposition:
- Package blast_pkg holds:
  - the nucleotide code localparams (A, G, T, C, N);
  - the LENGTH_CHAR, LENGTH_COUNTER and LENGTH_ARRAY defaults;
  - the FSM state encoding.
- Sub-module blast_seq_buf, instantiated twice (query, subject), contains:
  - the ASCII encoder and write port;
  - the length counter and full flag;
  - one sequential stream read port;
  - the 2*LENGTH_ARRAY registered lookup ports.
- Top level contains the FSM, the stream index counter and the sticky flags.

Test Plan:
- Write "ACGTN" to the query buffer, then lookup Q_address_F lanes = {0,1,2,3} -> next cycle lanes = {001,100,010,011}; q_len=5.
- Start with mode=2'b11, q_len=3 ("AGT"), s_len=2 ("CC") -> query_enable high for exactly 3 cycles (001,010,011), then sub_enable the very next cycle for 2 cycles (100,100), then done pulses once and busy drops.
- Start with mode=2'b10 (subject only) -> query_enable never asserts; subject streams s_len cycles. Start with both lengths 0 -> done one cycle after start, no enables.
- Lookup addresses {255,0,200,1} with len=2 -> contexts {0,buf[0],0,buf[1]}; lookup index 5 in the same cycle index 5 is written -> 0.
- Write LENGTH_ADN+1 bytes -> wr_ready low at full, ovf=1, len=128. Write byte "x" -> stored as 101, enc_err=1.
- Assert reset 4 cycles into a 10-code stream -> enables and datastreams are 0 the following cycle, lengths are 0, and a subsequent lookup returns 0.
